// File: rtl/sprinkler_icon_pkg.sv
// Shared types and constants for the sprinkler status icon.
// State encodings, pixel codes, sprite geometry and the alarm recolour helper.
package icon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SPRAY = 2'b01,
        ST_ALARM = 2'b10
    } icon_state_t;

    localparam logic [1:0] ICON_TRANSPARENT = 2'b00;
    localparam logic [1:0] ICON_OUTLINE     = 2'b01;
    localparam logic [1:0] ICON_ALERT       = 2'b10;
    localparam logic [1:0] ICON_WATER       = 2'b11;

    localparam int ICON_SIZE   = 16;
    localparam int ICON_FRAMES = 5;

    // In alarm every drawn pixel becomes red; transparent stays transparent.
    function automatic logic [1:0] recode_alert(input logic [1:0] code);
        logic [1:0] res;
        res = (code != ICON_TRANSPARENT) ? ICON_ALERT : ICON_TRANSPARENT;
        return res;
    endfunction

endpackage

// File: rtl/sprinkler_icon_if.sv
// Scan-position / status inputs and pixel outputs of the sprinkler icon.
// master = video pipeline side that drives scan and status, slave = icon block.
interface sprinkler_icon_if;

    logic        video_on;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        frame_tick;
    logic        sprinkler_on;
    logic        fault;
    logic [1:0]  icon;
    logic [1:0]  icon_state;

    modport master (
        output video_on, pixel_row, pixel_column, frame_tick, sprinkler_on, fault,
        input  icon, icon_state
    );

    modport slave (
        input  video_on, pixel_row, pixel_column, frame_tick, sprinkler_on, fault,
        output icon, icon_state
    );

endinterface

// File: rtl/sprinkler_icon_rom.sv
// Combinational 5-frame 16x16 sprite lookup for the sprinkler icon.
// Frame 0: sprinkler head outline only. Frames 1..4: head plus spray droplets
// whose diagonal pattern shifts by one pixel per frame. Out-of-range frames are blank.
module icon_rom
    import icon_pkg::*;
(
    input  logic [2:0] i_frame_sel,
    input  logic [3:0] i_y_off,
    input  logic [3:0] i_x_off,
    output logic [1:0] o_code
);

    logic       w_outline;
    logic       w_drop;
    logic [1:0] w_anim;
    logic [1:0] w_sum;

    // Sprite geometry: outline set, droplet set, then priority select.
    always_comb begin
        w_anim = i_frame_sel[1:0] - 2'd1;
        w_sum  = i_x_off[1:0] + i_y_off[1:0] + w_anim;

        w_outline = (i_y_off == 4'd15)
                 || ((i_y_off == 4'd0) && ((i_x_off == 4'd0) || (i_x_off == 4'd15)))
                 || ((i_x_off >= 4'd6) && (i_x_off <= 4'd9) && (i_y_off >= 4'd10) && (i_y_off <= 4'd14))
                 || ((i_y_off == 4'd9) && ((i_x_off == 4'd7) || (i_x_off == 4'd8)));

        w_drop = (i_y_off >= 4'd1) && (i_y_off <= 4'd7)
              && (i_x_off >= 4'd1) && (i_x_off <= 4'd14)
              && (w_sum == 2'd0);

        if (i_frame_sel >= 3'(ICON_FRAMES)) begin
            o_code = ICON_TRANSPARENT;
        end else if (w_outline) begin
            o_code = ICON_OUTLINE;
        end else if ((i_frame_sel != 3'd0) && w_drop) begin
            o_code = ICON_WATER;
        end else begin
            o_code = ICON_TRANSPARENT;
        end
    end

endmodule

// File: rtl/sprinkler_icon.sv
// Sprinkler icon pixel generator: 16x16 window hit test, frame-synchronous
// IDLE/SPRAY/ALARM state machine, spray animation and a registered pixel code
// with one clock of latency. Optional alarm blinking: SPRINKLER_ICON_BLINK_EN.
module sprinkler_icon
    import icon_pkg::*;
#(
    parameter logic [11:0] ICON_X          = 12'd100,
    parameter logic [11:0] ICON_Y          = 12'd200,
    parameter int          FRAMES_PER_STEP = 15,
    parameter int          BLINK_FRAMES    = 30
) (
    input  logic              clock,
    input  logic              reset,
    sprinkler_icon_if.slave   bus
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    icon_state_t     r_state;
    icon_state_t     w_state_nxt;
    logic [FC_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [1:0]      r_anim_idx, w_anim_idx_nxt;
    logic [1:0]      r_icon;

    logic [12:0]     w_col13, w_row13, w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic            w_hit;
    logic [3:0]      w_x_off, w_y_off;
    logic [2:0]      w_frame_sel;
    logic [1:0]      w_rom_code;
    logic [1:0]      w_code;
    logic            w_blank;

    // Window compare in 13 bits so ICON_X/Y+15 cannot wrap past 4095.
    always_comb begin
        w_col13 = {1'b0, bus.pixel_column};
        w_row13 = {1'b0, bus.pixel_row};
        w_x_lo  = {1'b0, ICON_X};
        w_y_lo  = {1'b0, ICON_Y};
        w_x_hi  = w_x_lo + 13'(ICON_SIZE - 1);
        w_y_hi  = w_y_lo + 13'(ICON_SIZE - 1);
        w_hit   = bus.video_on
               && (w_col13 >= w_x_lo) && (w_col13 <= w_x_hi)
               && (w_row13 >= w_y_lo) && (w_row13 <= w_y_hi);
        w_x_off = bus.pixel_column[3:0] - ICON_X[3:0];
        w_y_off = bus.pixel_row[3:0] - ICON_Y[3:0];
    end

    // Next state from the level inputs; fault outranks sprinkler_on.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.fault)             w_state_nxt = ST_ALARM;
                else if (bus.sprinkler_on) w_state_nxt = ST_SPRAY;
                else                       w_state_nxt = ST_IDLE;
            end
            ST_SPRAY: begin
                if (bus.fault)              w_state_nxt = ST_ALARM;
                else if (!bus.sprinkler_on) w_state_nxt = ST_IDLE;
                else                        w_state_nxt = ST_SPRAY;
            end
            ST_ALARM: begin
                if (!bus.fault) w_state_nxt = ST_IDLE;
                else            w_state_nxt = ST_ALARM;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Spray counters advance only while staying in SPRAY; otherwise they clear.
    always_comb begin
        w_frame_cnt_nxt = '0;
        w_anim_idx_nxt  = 2'd0;
        if ((r_state == ST_SPRAY) && (w_state_nxt == ST_SPRAY)) begin
            if (r_frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) begin
                w_frame_cnt_nxt = '0;
                w_anim_idx_nxt  = r_anim_idx + 2'd1;
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + FC_W'(1);
                w_anim_idx_nxt  = r_anim_idx;
            end
        end else begin
            w_frame_cnt_nxt = '0;
            w_anim_idx_nxt  = 2'd0;
        end
    end

    // State and spray counters change only on frame_tick, so the icon never tears.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_anim_idx  <= 2'd0;
        end else if (bus.frame_tick) begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_anim_idx  <= w_anim_idx_nxt;
        end else begin
            r_state     <= r_state;
            r_frame_cnt <= r_frame_cnt;
            r_anim_idx  <= r_anim_idx;
        end
    end

`ifdef SPRINKLER_ICON_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BC_W-1:0] r_blink_cnt;
    logic            r_blink_phase;

    // Blink counter runs on frame ticks while staying in ALARM; clears otherwise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (bus.frame_tick && (r_state == ST_ALARM) && (w_state_nxt == ST_ALARM)) begin
            if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BC_W'(1);
                r_blink_phase <= r_blink_phase;
            end
        end else if (bus.frame_tick) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_blink_cnt   <= r_blink_cnt;
            r_blink_phase <= r_blink_phase;
        end
    end

    assign w_blank = (r_state == ST_ALARM) && r_blink_phase;
`else
    assign w_blank = 1'b0;
`endif

    // Frame select from the current (pre-update) state.
    always_comb begin
        case (r_state)
            ST_IDLE:  w_frame_sel = 3'd0;
            ST_SPRAY: w_frame_sel = 3'd1 + {1'b0, r_anim_idx};
            ST_ALARM: w_frame_sel = 3'd0;
            default:  w_frame_sel = 3'd0;
        endcase
    end

    icon_rom u_rom (
        .i_frame_sel (w_frame_sel),
        .i_y_off     (w_y_off),
        .i_x_off     (w_x_off),
        .o_code      (w_rom_code)
    );

    // Recolour for alarm and apply the blink blanking.
    always_comb begin
        w_code = w_rom_code;
        if (w_blank) begin
            w_code = ICON_TRANSPARENT;
        end else if (r_state == ST_ALARM) begin
            w_code = recode_alert(w_rom_code);
        end else begin
            w_code = w_rom_code;
        end
    end

    // Registered pixel output keeps alignment with the 1-cycle map ROM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_icon <= ICON_TRANSPARENT;
        end else begin
            r_icon <= w_hit ? w_code : ICON_TRANSPARENT;
        end
    end

    assign bus.icon       = r_icon;
    assign bus.icon_state = r_state;

endmodule

// File: tb/tb_sprinkler_icon.sv
// Self-checking bench for sprinkler_icon: directed steps plus random scan and
// status traffic, compared against a tick-count based behavioural model.
module tb_sprinkler_icon;

    localparam int IX  = 100;
    localparam int IY  = 200;
    localparam int FPS = 4;
    localparam int BLK = 2;

    logic clock;
    logic rst_n;
    sprinkler_icon_if bus ();

    sprinkler_icon #(
        .ICON_X          (12'd100),
        .ICON_Y          (12'd200),
        .FRAMES_PER_STEP (FPS),
        .BLINK_FRAMES    (BLK)
    ) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: state 0/1/2 and number of frame ticks seen since entering it.
    int m_state = 0;
    int m_k     = 0;

    function automatic int sprite(input int f, input int x, input int y);
        if (y == 15) return 1;
        if (y == 0 && (x == 0 || x == 15)) return 1;
        if (x >= 6 && x <= 9 && y >= 10 && y <= 14) return 1;
        if (y == 9 && (x == 7 || x == 8)) return 1;
        if (f > 0 && y >= 1 && y <= 7 && x >= 1 && x <= 14 && ((x + y + f - 1) % 4) == 0) return 3;
        return 0;
    endfunction

    function automatic logic [1:0] exp_icon(input int row, input int col, input bit von);
        int v;
        if (!(von && col >= IX && col <= IX + 15 && row >= IY && row <= IY + 15)) return 2'b00;
        if (m_state == 1) begin
            v = sprite(1 + (m_k / FPS) % 4, col - IX, row - IY);
        end else if (m_state == 2) begin
            v = (sprite(0, col - IX, row - IY) != 0) ? 2 : 0;
`ifdef SPRINKLER_ICON_BLINK_EN
            if (((m_k / BLK) % 2) == 1) v = 0;
`endif
        end else begin
            v = sprite(0, col - IX, row - IY);
        end
        return 2'(v);
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One pixel clock: present inputs, predict, clock, compare, advance model.
    task automatic step(input int row, input int col, input bit von, input bit tick, input string tag);
        logic [1:0] e_icon;
        int ns;
        bus.pixel_row    = 12'(row);
        bus.pixel_column = 12'(col);
        bus.video_on     = von;
        bus.frame_tick   = tick;
        e_icon = rst_n ? exp_icon(row, col, von) : 2'b00;
        @(posedge clock);
        #1;
        if (!rst_n) begin
            m_state = 0;
            m_k     = 0;
        end else if (tick) begin
            if (bus.fault)                          ns = 2;
            else if (m_state == 2)                  ns = 0;
            else if (bus.sprinkler_on)              ns = 1;
            else                                    ns = 0;
            m_k     = (ns == m_state) ? m_k + 1 : 0;
            m_state = ns;
        end
        check({tag, "_icon"}, bus.icon, e_icon);
        check({tag, "_state"}, bus.icon_state, 2'(m_state));
        bus.frame_tick = 1'b0;
    endtask

    task automatic scan_row(input int row, input string tag);
        for (int c = IX; c < IX + 16; c++) step(row, c, 1'b1, 1'b0, tag);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.video_on     = 1'b1;
        bus.pixel_row    = 12'd200;
        bus.pixel_column = 12'd100;
        bus.frame_tick   = 1'b0;
        bus.sprinkler_on = 1'b0;
        bus.fault        = 1'b0;

        // Reset held with a hit pixel present.
        for (int i = 0; i < 3; i++) step(200, 100, 1'b1, 1'b0, "reset");
        rst_n = 1'b1;
        step(200, 100, 1'b1, 1'b0, "post_reset_corner");
        step(215, 107, 1'b1, 1'b0, "post_reset_ground");

        // Window edges and video_on gating.
        step(200,  99, 1'b1, 1'b0, "edge_col99");
        step(200, 100, 1'b1, 1'b0, "edge_col100");
        step(200, 115, 1'b1, 1'b0, "edge_col115");
        step(200, 116, 1'b1, 1'b0, "edge_col116");
        step(200, 100, 1'b0, 1'b0, "edge_video_off");
        step(199, 100, 1'b1, 1'b0, "edge_row199");
        step(216, 100, 1'b1, 1'b0, "edge_row216");
        step(200, 4095, 1'b1, 1'b0, "edge_col4095");

        // Spray animation across more than a full anim_idx cycle.
        bus.sprinkler_on = 1'b1;
        step(0, 0, 1'b0, 1'b1, "spray_enter");
        for (int t = 0; t < 18; t++) begin
            scan_row(203, "spray_row");
            step(0, 0, 1'b0, 1'b1, "spray_tick");
        end

        // Level toggles between ticks are ignored; tick with hit shows old state.
        bus.sprinkler_on = 1'b0;
        step(203, 103, 1'b1, 1'b0, "midframe_low");
        bus.sprinkler_on = 1'b1;
        step(203, 104, 1'b1, 1'b0, "midframe_high");
        step(0, 0, 1'b0, 1'b1, "midframe_tick_hold");
        bus.sprinkler_on = 1'b0;
        for (int c = IX; c < IX + 8; c++) step(203, c, 1'b1, (c == IX + 3), "tick_on_hit");
        step(0, 0, 1'b0, 1'b1, "idle_hold");

        // Fault outranks sprinkler_on; whole window recoloured.
        bus.sprinkler_on = 1'b1;
        bus.fault        = 1'b1;
        step(0, 0, 1'b0, 1'b1, "fault_prio");
        for (int r = IY; r < IY + 16; r++) scan_row(r, "alarm_win");
        // Blink phases over several ticks.
        for (int t = 0; t < 6; t++) begin
            step(0, 0, 1'b0, 1'b1, "alarm_tick");
            step(200, 100, 1'b1, 1'b0, "alarm_corner");
            step(215, 110, 1'b1, 1'b0, "alarm_ground");
        end
        bus.fault = 1'b0;
        step(0, 0, 1'b0, 1'b1, "alarm_exit");
        step(215, 110, 1'b1, 1'b0, "after_alarm");

        // Randomized scan and status traffic.
        for (int i = 0; i < 1500; i++) begin
            bit tick;
            tick = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.sprinkler_on = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus.fault = ($urandom_range(0, 3) == 0);
            step(int'($urandom_range(196, 219)), int'($urandom_range(96, 119)),
                 ($urandom_range(0, 9) != 0), tick, "rand");
        end

        // Reset in the middle of a frame blanks the next pixel.
        bus.fault        = 1'b0;
        bus.sprinkler_on = 1'b1;
        step(0, 0, 1'b0, 1'b1, "pre_rst_tick");
        rst_n = 1'b0;
        step(215, 100, 1'b1, 1'b0, "midframe_reset");
        rst_n = 1'b1;
        step(215, 100, 1'b1, 1'b0, "after_midframe_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprinkler_icon.md
Name: sprinkler_icon

Overview:
- Icon pixel generator directly upstream of the colorizer; drives one of its 2-bit icon inputs.
- Compares the pixel_row/pixel_column scan position from the display timing generator against a fixed 16x16 icon window.
- Outputs a 2-bit pixel code for an animated sprinkler sprite.
- Icon state is set by sprinkler/fault status from the MIPS/MQTT side and changes only at frame boundaries, so the icon never tears.

Parameters:
- ICON_X, 12'd100, left column of icon window
- ICON_Y, 12'd200, top row of icon window
- FRAMES_PER_STEP, 15, video frames per spray animation step (>=1)
- BLINK_FRAMES, 30, video frames per alarm blink half-period (>=1)

Ports:
- clock  in  1  75 MHz pixel clock
- reset  in  1  synchronous, active-low reset
- video_on  in  1  active-video flag from display timing generator
- pixel_row  in  12  current scan row
- pixel_column  in  12  current scan column
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- sprinkler_on  in  1  sprinkler valve commanded on (level)
- fault  in  1  moisture/obstruction fault (level)
- icon  out  2  pixel code to colorizer: 00 transparent, 01 outline/black, 10 alert/red, 11 water/blue
- icon_state  out  2  current FSM state encoding, for status LEDs

Behaviour:
- Reset: all registers clear on the clock edge with reset low.
  - icon=00, icon_state=IDLE (00), frame_cnt=0, anim_idx=0, blink_cnt=0, blink_phase=0.
  - Reset mid-frame: icon is 00 from the next cycle.
- Hit test: hit = video_on && ICON_X<=col<=ICON_X+15 && ICON_Y<=row<=ICON_Y+15.
  - Offsets are col-ICON_X and row-ICON_Y, truncated to 4 bits.
  - Comparisons are done in 13 bits so the window never wraps at 4095.
- Latency: exactly 1 clock from pixel_row/pixel_column/video_on to icon. This matches the 1-cycle world map ROM so both colorizer inputs stay aligned. Output is registered.
- When hit=0: icon=00.
- FSM states: IDLE=00, SPRAY=01, ALARM=10. State is updated only on cycles where frame_tick=1.
  - fault=1 -> ALARM from any state. fault has priority over sprinkler_on.
  - ALARM with fault=0 -> IDLE.
  - IDLE with sprinkler_on=1 -> SPRAY.
  - SPRAY with sprinkler_on=0 -> IDLE.
  - Otherwise the state holds.
- Spray animation:
  - On entry to SPRAY: frame_cnt=0, anim_idx=0.
  - Each frame_tick while in SPRAY: frame_cnt increments. When it reaches FRAMES_PER_STEP-1 it wraps to 0 and anim_idx increments mod 4.
  - Counters are held at 0 outside SPRAY.
- ROM frame select:
  - IDLE -> frame 0 (sprinkler head only, codes 00/01).
  - SPRAY -> frame 1+anim_idx (head 01, droplets 11).
  - ALARM -> frame 0, with every non-zero code recoded to 10.
- Alarm blink:
  - On entry to ALARM: blink_cnt=0, blink_phase=0.
  - blink_cnt counts frame_ticks; phase toggles on reaching BLINK_FRAMES-1.
  - Phase 1 forces icon=00 inside the window.
- Same-cycle events: when frame_tick coincides with a hit pixel, that pixel uses the pre-update state. A new state takes effect on the following cycle, which is always inside blanking.
- Level inputs are sampled only at frame_tick. Pulses shorter than a frame between ticks are ignored.

Optional Feature:
- Macro: SPRINKLER_ICON_BLINK_EN.
- Defined: ALARM blinks as described above.
- Undefined: blink_cnt and blink_phase are not built; ALARM shows steady frame 0 recoded to 10.

Decomposition:
- Shared package icon_pkg holds:
  - state typedef (IDLE/SPRAY/ALARM) and its 2-bit encodings
  - pixel code constants ICON_TRANSPARENT=2'b00, ICON_OUTLINE=2'b01, ICON_ALERT=2'b10, ICON_WATER=2'b11
  - ICON_SIZE=16 and the frame count (5)
- One sub-module, icon_rom: combinational lookup of {frame_sel[2:0], y_off[3:0], x_off[3:0]} -> 2-bit code, 5x256 entries. The parent registers its output.

Test Plan:
- Reset: hold reset low 3 cycles with a hit pixel (row 200, col 100, video_on=1) -> icon=00, icon_state=00 throughout; after release, IDLE frame-0 code appears 1 cycle after each pixel.
- Window edges: scan row 200, cols 99/100/115/116 -> icon 00 / ROM(0,0,0) / ROM(0,0,15) / 00, each 1 cycle late; video_on=0 at col 100 -> 00.
- Spray animation (FRAMES_PER_STEP=4): sprinkler_on=1, frame_tick -> icon_state=01; anim_idx steps 0,1,2,3,0 every 4 ticks; droplet pixels read 11.
- Fault priority: sprinkler_on=1 and fault=1 at the same frame_tick -> ALARM (10); every non-zero pixel is 10; fault=0 at next tick -> IDLE.
- Blink (BLINK_FRAMES=2, macro on): in ALARM, window is lit for ticks 0-1, blank (00) for ticks 2-3, repeating. Macro off: steady 10.
- Mid-frame inputs: toggle sprinkler_on 1->0->1 between two frame_ticks -> no state change; a frame_tick in the same cycle as a hit pixel -> that pixel shows the old state.
